// File: rtl/frv_axi_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : frv_axi_arbiter_2to1
// Brief    : Merges two AXI4-lite master ports (instruction/data adapters)
//            onto one downstream AXI4-lite port. One transaction in flight,
//            round-robin or fixed-priority port choice, responses routed
//            back to the issuing port.
// Revision : 1.0 - initial release
// ============================================================================
module frv_axi_arbiter_2to1 #(
    parameter int ARB_RR   = 1,  // 1: round-robin, 0: s0 always wins
    parameter int WR_FIRST = 1   // 1: write beats read within a port
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    // upstream port 0
    input  logic        s0_axi_awvalid,
    output logic        s0_axi_awready,
    input  logic [31:0] s0_axi_awaddr,
    input  logic [2:0]  s0_axi_awprot,
    input  logic        s0_axi_wvalid,
    output logic        s0_axi_wready,
    input  logic [31:0] s0_axi_wdata,
    input  logic [3:0]  s0_axi_wstrb,
    output logic        s0_axi_bvalid,
    input  logic        s0_axi_bready,
    output logic [1:0]  s0_axi_bresp,
    input  logic        s0_axi_arvalid,
    output logic        s0_axi_arready,
    input  logic [31:0] s0_axi_araddr,
    input  logic [2:0]  s0_axi_arprot,
    output logic        s0_axi_rvalid,
    input  logic        s0_axi_rready,
    output logic [31:0] s0_axi_rdata,
    output logic [1:0]  s0_axi_rresp,
    // upstream port 1
    input  logic        s1_axi_awvalid,
    output logic        s1_axi_awready,
    input  logic [31:0] s1_axi_awaddr,
    input  logic [2:0]  s1_axi_awprot,
    input  logic        s1_axi_wvalid,
    output logic        s1_axi_wready,
    input  logic [31:0] s1_axi_wdata,
    input  logic [3:0]  s1_axi_wstrb,
    output logic        s1_axi_bvalid,
    input  logic        s1_axi_bready,
    output logic [1:0]  s1_axi_bresp,
    input  logic        s1_axi_arvalid,
    output logic        s1_axi_arready,
    input  logic [31:0] s1_axi_araddr,
    input  logic [2:0]  s1_axi_arprot,
    output logic        s1_axi_rvalid,
    input  logic        s1_axi_rready,
    output logic [31:0] s1_axi_rdata,
    output logic [1:0]  s1_axi_rresp,
    // downstream port
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRSP  = 3'd2,
        ST_RADDR = 3'd3,
        ST_RRSP  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;
    logic   r_gnt_id, w_gnt_id_nxt;
    logic   r_gnt_wr, w_gnt_wr_nxt;
    logic   r_last, w_last_nxt;
    logic   r_aw_done, w_aw_done_nxt;
    logic   r_w_done, w_w_done_nxt;

    logic w_wr_req0, w_wr_req1, w_rd_req0, w_rd_req1, w_req0, w_req1;
    logic w_pick, w_pick_wr;
    logic w_aw_hs, w_w_hs;

    // granted-port view of upstream valids/readies
    logic w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;
    // handshake signals presented to the granted port only
    logic w_g_awready, w_g_wready, w_g_bvalid, w_g_arready, w_g_rvalid;

    assign w_wr_req0 = s0_axi_awvalid | s0_axi_wvalid;
    assign w_wr_req1 = s1_axi_awvalid | s1_axi_wvalid;
    assign w_rd_req0 = s0_axi_arvalid;
    assign w_rd_req1 = s1_axi_arvalid;
    assign w_req0    = w_wr_req0 | w_rd_req0;
    assign w_req1    = w_wr_req1 | w_rd_req1;

    assign w_g_awvalid = r_gnt_id ? s1_axi_awvalid : s0_axi_awvalid;
    assign w_g_wvalid  = r_gnt_id ? s1_axi_wvalid  : s0_axi_wvalid;
    assign w_g_bready  = r_gnt_id ? s1_axi_bready  : s0_axi_bready;
    assign w_g_arvalid = r_gnt_id ? s1_axi_arvalid : s0_axi_arvalid;
    assign w_g_rready  = r_gnt_id ? s1_axi_rready  : s0_axi_rready;

    // Payload mux keys off the registered grant only, so it cannot move
    // while a downstream valid is asserted.
    assign m_axi_awaddr = r_gnt_id ? s1_axi_awaddr : s0_axi_awaddr;
    assign m_axi_awprot = r_gnt_id ? s1_axi_awprot : s0_axi_awprot;
    assign m_axi_wdata  = r_gnt_id ? s1_axi_wdata  : s0_axi_wdata;
    assign m_axi_wstrb  = r_gnt_id ? s1_axi_wstrb  : s0_axi_wstrb;
    assign m_axi_araddr = r_gnt_id ? s1_axi_araddr : s0_axi_araddr;
    assign m_axi_arprot = r_gnt_id ? s1_axi_arprot : s0_axi_arprot;

    // Response payloads are broadcast; only the granted port sees a valid.
    assign s0_axi_bresp = m_axi_bresp;
    assign s1_axi_bresp = m_axi_bresp;
    assign s0_axi_rdata = m_axi_rdata;
    assign s1_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s1_axi_rresp = m_axi_rresp;

    assign s0_axi_awready = w_g_awready & ~r_gnt_id;
    assign s1_axi_awready = w_g_awready &  r_gnt_id;
    assign s0_axi_wready  = w_g_wready  & ~r_gnt_id;
    assign s1_axi_wready  = w_g_wready  &  r_gnt_id;
    assign s0_axi_bvalid  = w_g_bvalid  & ~r_gnt_id;
    assign s1_axi_bvalid  = w_g_bvalid  &  r_gnt_id;
    assign s0_axi_arready = w_g_arready & ~r_gnt_id;
    assign s1_axi_arready = w_g_arready &  r_gnt_id;
    assign s0_axi_rvalid  = w_g_rvalid  & ~r_gnt_id;
    assign s1_axi_rvalid  = w_g_rvalid  &  r_gnt_id;

    // Port choice and write/read choice for a new grant
    always_comb begin
        w_pick    = 1'b0;
        w_pick_wr = 1'b0;
        if (ARB_RR != 0) begin
            if (w_req0 && w_req1) w_pick = ~r_last;
            else                  w_pick = w_req1;
        end else begin
            w_pick = ~w_req0;
        end
        if (w_pick) w_pick_wr = (WR_FIRST != 0) ? w_wr_req1 : ~w_rd_req1;
        else        w_pick_wr = (WR_FIRST != 0) ? w_wr_req0 : ~w_rd_req0;
    end

    // Next-state and handshake steering for the single in-flight transaction
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_id_nxt  = r_gnt_id;
        w_gnt_wr_nxt  = r_gnt_wr;
        w_last_nxt    = r_last;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        w_g_awready   = 1'b0;
        w_g_wready    = 1'b0;
        w_g_bvalid    = 1'b0;
        w_g_arready   = 1'b0;
        w_g_rvalid    = 1'b0;
        w_aw_hs       = 1'b0;
        w_w_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_gnt_id_nxt = w_pick;
                    w_gnt_wr_nxt = w_pick_wr;
                    w_state_nxt  = w_pick_wr ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                m_axi_awvalid = w_g_awvalid & ~r_aw_done;
                m_axi_wvalid  = w_g_wvalid  & ~r_w_done;
                w_g_awready   = m_axi_awready & ~r_aw_done;
                w_g_wready    = m_axi_wready  & ~r_w_done;
                w_aw_hs       = m_axi_awvalid & m_axi_awready;
                w_w_hs        = m_axi_wvalid  & m_axi_wready;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = ST_WRSP;
                end else begin
                    w_aw_done_nxt = r_aw_done | w_aw_hs;
                    w_w_done_nxt  = r_w_done  | w_w_hs;
                end
            end
            ST_WRSP: begin
                // a B is only forwarded while a write holds the grant
                if (r_gnt_wr) begin
                    w_g_bvalid   = m_axi_bvalid;
                    m_axi_bready = w_g_bready;
                    if (m_axi_bvalid && w_g_bready) begin
                        w_last_nxt  = r_gnt_id;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RADDR: begin
                m_axi_arvalid = w_g_arvalid;
                w_g_arready   = m_axi_arready;
                if (w_g_arvalid && m_axi_arready) w_state_nxt = ST_RRSP;
            end
            ST_RRSP: begin
                if (!r_gnt_wr) begin
                    w_g_rvalid   = m_axi_rvalid;
                    m_axi_rready = w_g_rready;
                    if (m_axi_rvalid && w_g_rready) begin
                        w_last_nxt  = r_gnt_id;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transaction immediately
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state   <= ST_IDLE;
            r_gnt_id  <= 1'b0;
            r_gnt_wr  <= 1'b0;
            r_last    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_gnt_wr  <= w_gnt_wr_nxt;
            r_last    <= w_last_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frv_axi_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_frv_axi_arbiter_2to1
// Brief    : Directed bench for frv_axi_arbiter_2to1. Instance 0 is
//            round-robin, instance 1 fixed-priority; the bench acts as both
//            upstream masters and the downstream slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frv_axi_arbiter_2to1;

    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    // upstream stimulus [dut][port]
    logic        s_awvalid [2][2];
    logic [31:0] s_awaddr  [2][2];
    logic [2:0]  s_awprot  [2][2];
    logic        s_wvalid  [2][2];
    logic [31:0] s_wdata   [2][2];
    logic [3:0]  s_wstrb   [2][2];
    logic        s_bready  [2][2];
    logic        s_arvalid [2][2];
    logic [31:0] s_araddr  [2][2];
    logic [2:0]  s_arprot  [2][2];
    logic        s_rready  [2][2];
    wire         s_awready [2][2];
    wire         s_wready  [2][2];
    wire         s_bvalid  [2][2];
    wire  [1:0]  s_bresp   [2][2];
    wire         s_arready [2][2];
    wire         s_rvalid  [2][2];
    wire  [31:0] s_rdata   [2][2];
    wire  [1:0]  s_rresp   [2][2];
    // downstream slave side [dut]
    logic        m_awready [2];
    logic        m_wready  [2];
    logic        m_bvalid  [2];
    logic [1:0]  m_bresp   [2];
    logic        m_arready [2];
    logic        m_rvalid  [2];
    logic [31:0] m_rdata   [2];
    logic [1:0]  m_rresp   [2];
    wire         m_awvalid [2];
    wire  [31:0] m_awaddr  [2];
    wire  [2:0]  m_awprot  [2];
    wire         m_wvalid  [2];
    wire  [31:0] m_wdata   [2];
    wire  [3:0]  m_wstrb   [2];
    wire         m_bready  [2];
    wire         m_arvalid [2];
    wire  [31:0] m_araddr  [2];
    wire  [2:0]  m_arprot  [2];
    wire         m_rready  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            frv_axi_arbiter_2to1 #(.ARB_RR(gi == 0 ? 1 : 0), .WR_FIRST(1)) u_dut (
                .g_clk(g_clk), .g_resetn(g_resetn),
                .s0_axi_awvalid(s_awvalid[gi][0]), .s0_axi_awready(s_awready[gi][0]),
                .s0_axi_awaddr(s_awaddr[gi][0]),   .s0_axi_awprot(s_awprot[gi][0]),
                .s0_axi_wvalid(s_wvalid[gi][0]),   .s0_axi_wready(s_wready[gi][0]),
                .s0_axi_wdata(s_wdata[gi][0]),     .s0_axi_wstrb(s_wstrb[gi][0]),
                .s0_axi_bvalid(s_bvalid[gi][0]),   .s0_axi_bready(s_bready[gi][0]),
                .s0_axi_bresp(s_bresp[gi][0]),
                .s0_axi_arvalid(s_arvalid[gi][0]), .s0_axi_arready(s_arready[gi][0]),
                .s0_axi_araddr(s_araddr[gi][0]),   .s0_axi_arprot(s_arprot[gi][0]),
                .s0_axi_rvalid(s_rvalid[gi][0]),   .s0_axi_rready(s_rready[gi][0]),
                .s0_axi_rdata(s_rdata[gi][0]),     .s0_axi_rresp(s_rresp[gi][0]),
                .s1_axi_awvalid(s_awvalid[gi][1]), .s1_axi_awready(s_awready[gi][1]),
                .s1_axi_awaddr(s_awaddr[gi][1]),   .s1_axi_awprot(s_awprot[gi][1]),
                .s1_axi_wvalid(s_wvalid[gi][1]),   .s1_axi_wready(s_wready[gi][1]),
                .s1_axi_wdata(s_wdata[gi][1]),     .s1_axi_wstrb(s_wstrb[gi][1]),
                .s1_axi_bvalid(s_bvalid[gi][1]),   .s1_axi_bready(s_bready[gi][1]),
                .s1_axi_bresp(s_bresp[gi][1]),
                .s1_axi_arvalid(s_arvalid[gi][1]), .s1_axi_arready(s_arready[gi][1]),
                .s1_axi_araddr(s_araddr[gi][1]),   .s1_axi_arprot(s_arprot[gi][1]),
                .s1_axi_rvalid(s_rvalid[gi][1]),   .s1_axi_rready(s_rready[gi][1]),
                .s1_axi_rdata(s_rdata[gi][1]),     .s1_axi_rresp(s_rresp[gi][1]),
                .m_axi_awvalid(m_awvalid[gi]), .m_axi_awready(m_awready[gi]),
                .m_axi_awaddr(m_awaddr[gi]),   .m_axi_awprot(m_awprot[gi]),
                .m_axi_wvalid(m_wvalid[gi]),   .m_axi_wready(m_wready[gi]),
                .m_axi_wdata(m_wdata[gi]),     .m_axi_wstrb(m_wstrb[gi]),
                .m_axi_bvalid(m_bvalid[gi]),   .m_axi_bready(m_bready[gi]),
                .m_axi_bresp(m_bresp[gi]),
                .m_axi_arvalid(m_arvalid[gi]), .m_axi_arready(m_arready[gi]),
                .m_axi_araddr(m_araddr[gi]),   .m_axi_arprot(m_arprot[gi]),
                .m_axi_rvalid(m_rvalid[gi]),   .m_axi_rready(m_rready[gi]),
                .m_axi_rdata(m_rdata[gi]),     .m_axi_rresp(m_rresp[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } sb_item_t;

    sb_item_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // slave read data is a fixed function of the address (0x100 -> 0xDEADBEEF)
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    function automatic logic [4:0] port_ctl(input int d, input int q);
        return {s_awready[d][q], s_wready[d][q], s_bvalid[d][q], s_arready[d][q], s_rvalid[d][q]};
    endfunction

    function automatic logic [14:0] all_ctl(input int d);
        return {port_ctl(d, 0), port_ctl(d, 1),
                m_awvalid[d], m_wvalid[d], m_bready[d], m_arvalid[d], m_rready[d]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                s_awvalid[d][p] = 1'b0; s_awaddr[d][p] = '0; s_awprot[d][p] = '0;
                s_wvalid[d][p]  = 1'b0; s_wdata[d][p]  = '0; s_wstrb[d][p]  = '0;
                s_arvalid[d][p] = 1'b0; s_araddr[d][p] = '0; s_arprot[d][p] = '0;
                s_bready[d][p]  = 1'b1; s_rready[d][p] = 1'b1;
            end
            m_awready[d] = 1'b0; m_wready[d] = 1'b0; m_arready[d] = 1'b0;
            m_bvalid[d]  = 1'b0; m_bresp[d]  = '0;
            m_rvalid[d]  = 1'b0; m_rdata[d]  = '0; m_rresp[d] = '0;
        end
    endtask

    // returns at posedge+1 with both instances idle and out of reset
    task automatic do_reset();
        @(posedge g_clk); #1;
        g_resetn = 1'b0;
        clear_inputs();
        #1;
        chk("rst_ctl_d0", 32'(all_ctl(0)), 32'd0);
        chk("rst_ctl_d1", 32'(all_ctl(1)), 32'd0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
    endtask

    // Acts as slave for one transaction expected from port p of instance d.
    // Enter at posedge+1 with the request already driven.
    task automatic serve(input int d, input int p, input bit wr, input int aw_wait,
                         input int w_wait, input logic [1:0] resp, input bit hold);
        sb_item_t    it;
        int          n;
        bit          aw_ok, w_ok, ar_ok, hs_aw, hs_w, hs_ar, first, done;
        logic [31:0] cap_addr;
        it.resp = resp;
        it.data = wr ? 32'd0 : rd_model(s_araddr[d][p]);
        sb.push_back(it);
        n = 0; aw_ok = 0; w_ok = 0; ar_ok = 0; first = 1; done = 0; cap_addr = '0;
        m_awready[d] = (aw_wait == 0);
        m_wready[d]  = (w_wait == 0);
        m_arready[d] = 1'b1;
        while (!(wr ? (aw_ok && w_ok) : ar_ok) && n < 20) begin
            #1;
            chk("addr_other_quiet", 32'(port_ctl(d, 1 - p)), 32'd0);
            hs_aw = m_awvalid[d] && m_awready[d];
            hs_w  = m_wvalid[d]  && m_wready[d];
            hs_ar = m_arvalid[d] && m_arready[d];
            if (first && (m_awvalid[d] || m_wvalid[d] || m_arvalid[d])) begin
                first = 0;
                chk("req_latency", 32'(n), 32'd1);
            end
            if (wr) begin
                chk("wr_no_rd", 32'({m_arvalid[d], m_rready[d], m_bready[d]}), 32'd0);
                if (aw_ok) chk("aw_done_gate", 32'(m_awvalid[d]), 32'd0);
                if (w_ok)  chk("w_done_gate", 32'(m_wvalid[d]), 32'd0);
                if (hs_aw) begin
                    chk("awaddr", m_awaddr[d], s_awaddr[d][p]);
                    chk("awprot", 32'(m_awprot[d]), 32'(s_awprot[d][p]));
                    chk("s_awready", 32'(s_awready[d][p]), 32'd1);
                end
                if (hs_w) begin
                    chk("wdata", m_wdata[d], s_wdata[d][p]);
                    chk("wstrb", 32'(m_wstrb[d]), 32'(s_wstrb[d][p]));
                    chk("s_wready", 32'(s_wready[d][p]), 32'd1);
                end
            end else begin
                chk("rd_no_wr", 32'({m_awvalid[d], m_wvalid[d], m_bready[d], m_rready[d],
                                     s_bvalid[d][p]}), 32'd0);
                if (hs_ar) begin
                    chk("araddr", m_araddr[d], s_araddr[d][p]);
                    chk("arprot", 32'(m_arprot[d]), 32'(s_arprot[d][p]));
                    chk("s_arready", 32'(s_arready[d][p]), 32'd1);
                    cap_addr = m_araddr[d];
                end
            end
            @(posedge g_clk); #1;
            n++;
            if (hs_aw) aw_ok = 1;
            if (hs_w)  w_ok  = 1;
            if (hs_ar) ar_ok = 1;
            if (n >= aw_wait) m_awready[d] = 1'b1;
            if (n >= w_wait)  m_wready[d]  = 1'b1;
        end
        chk("addr_phase_done", 32'(wr ? (aw_ok && w_ok) : ar_ok), 32'd1);
        m_awready[d] = 1'b0; m_wready[d] = 1'b0; m_arready[d] = 1'b0;
        if (!hold) begin
            if (wr) begin s_awvalid[d][p] = 1'b0; s_wvalid[d][p] = 1'b0; end
            else          s_arvalid[d][p] = 1'b0;
        end
        // response phase
        if (wr) begin
            m_bvalid[d] = 1'b1; m_bresp[d] = resp;
        end else begin
            m_rvalid[d] = 1'b1; m_rdata[d] = rd_model(cap_addr); m_rresp[d] = resp;
        end
        n = 0;
        while (!done && n < 20) begin
            #1;
            chk("rsp_other_quiet", 32'(port_ctl(d, 1 - p)), 32'd0);
            if (wr) begin
                chk("wrsp_no_r", 32'({m_arvalid[d], m_awvalid[d], m_wvalid[d], m_rready[d],
                                      s_rvalid[d][p]}), 32'd0);
                if (s_bvalid[d][p] && s_bready[d][p]) begin
                    done = 1;
                    chk("m_bready", 32'(m_bready[d]), 32'd1);
                    chk("sb_has_item", 32'(sb.size() == 0), 32'd0);
                    if (sb.size() != 0) begin
                        it = sb.pop_front();
                        chk("bresp", 32'(s_bresp[d][p]), 32'(it.resp));
                    end
                end
            end else begin
                chk("rrsp_no_b", 32'({m_bready[d], m_arvalid[d], s_bvalid[d][p]}), 32'd0);
                if (s_rvalid[d][p] && s_rready[d][p]) begin
                    done = 1;
                    chk("m_rready", 32'(m_rready[d]), 32'd1);
                    chk("sb_has_item", 32'(sb.size() == 0), 32'd0);
                    if (sb.size() != 0) begin
                        it = sb.pop_front();
                        chk("rdata", s_rdata[d][p], it.data);
                        chk("rresp", 32'(s_rresp[d][p]), 32'(it.resp));
                    end
                end
            end
            @(posedge g_clk); #1;
            n++;
        end
        chk("rsp_phase_done", 32'(done), 32'd1);
        if (!done && sb.size() != 0) void'(sb.pop_front());
        m_bvalid[d] = 1'b0;
        m_rvalid[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        g_resetn = 1'b0;
        clear_inputs();
        #1;
        chk("por_ctl_d0", 32'(all_ctl(0)), 32'd0);
        chk("por_ctl_d1", 32'(all_ctl(1)), 32'd0);
        do_reset();

        // single read on s0
        s_araddr[0][0] = 32'h100; s_arprot[0][0] = 3'd2; s_arvalid[0][0] = 1'b1;
        serve(0, 0, 0, 0, 0, 2'b00, 0);

        // split write on s1: AW first, W two cycles later, SLVERR response
        s_awaddr[0][1] = 32'h2000; s_awprot[0][1] = 3'd1; s_awvalid[0][1] = 1'b1;
        s_wdata[0][1]  = 32'h55AA; s_wstrb[0][1]  = 4'hF; s_wvalid[0][1]  = 1'b1;
        serve(0, 1, 1, 0, 3, 2'b10, 0);

        // W accepted before AW
        s_awaddr[0][0] = 32'h3004; s_awprot[0][0] = 3'd0; s_awvalid[0][0] = 1'b1;
        s_wdata[0][0]  = 32'h1234_5678; s_wstrb[0][0] = 4'h3; s_wvalid[0][0] = 1'b1;
        serve(0, 0, 1, 2, 0, 2'b00, 0);

        // write and read pending on one port: write first, then read with DECERR
        s_awaddr[0][0] = 32'h40; s_awvalid[0][0] = 1'b1;
        s_wdata[0][0]  = 32'hCAFE_F00D; s_wstrb[0][0] = 4'hC; s_wvalid[0][0] = 1'b1;
        s_araddr[0][0] = 32'h44; s_arvalid[0][0] = 1'b1;
        serve(0, 0, 1, 0, 0, 2'b00, 0);
        serve(0, 0, 0, 0, 0, 2'b11, 0);

        // stray B while idle and during a read
        m_bvalid[0] = 1'b1; m_bresp[0] = 2'b01;
        #1;
        chk("stray_b_idle", 32'({m_bready[0], s_bvalid[0][0], s_bvalid[0][1]}), 32'd0);
        s_araddr[0][1] = 32'h80; s_arvalid[0][1] = 1'b1;
        serve(0, 1, 0, 0, 0, 2'b00, 0);
        m_bvalid[0] = 1'b0;

        // round-robin contention from reset: s0, s1, s0, s1
        do_reset();
        s_araddr[0][0] = 32'h100; s_arvalid[0][0] = 1'b1;
        s_araddr[0][1] = 32'h200; s_arvalid[0][1] = 1'b1;
        serve(0, 0, 0, 0, 0, 2'b00, 1);
        serve(0, 1, 0, 0, 0, 2'b00, 1);
        serve(0, 0, 0, 0, 0, 2'b00, 1);
        serve(0, 1, 0, 0, 0, 2'b00, 1);
        s_arvalid[0][0] = 1'b0; s_arvalid[0][1] = 1'b0;

        // fixed priority: s0 always wins until it drops its request
        do_reset();
        s_araddr[1][0] = 32'h500; s_arvalid[1][0] = 1'b1;
        s_araddr[1][1] = 32'h600; s_arvalid[1][1] = 1'b1;
        serve(1, 0, 0, 0, 0, 2'b00, 1);
        serve(1, 0, 0, 0, 0, 2'b00, 1);
        serve(1, 0, 0, 0, 0, 2'b00, 1);
        s_arvalid[1][0] = 1'b0;
        serve(1, 1, 0, 0, 0, 2'b00, 0);

        // async reset in WADDR with AW already accepted
        do_reset();
        s_awaddr[0][0] = 32'h7000; s_awvalid[0][0] = 1'b1;
        s_wdata[0][0]  = 32'hA5A5_5A5A; s_wstrb[0][0] = 4'hF; s_wvalid[0][0] = 1'b1;
        m_awready[0] = 1'b1; m_wready[0] = 1'b0;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        chk("pre_rst_aw_done", 32'({m_awvalid[0], m_wvalid[0]}), 32'b01);
        g_resetn = 1'b0;
        m_awready[0] = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'(all_ctl(0)), 32'd0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        serve(0, 0, 1, 0, 0, 2'b00, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
